reg_bank_arb: RTL and testbench
===============================

REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 Parameter DW, default 8: data width of each bank entry and of both write/read data buses.
REQ-002 Parameter AW, default 2: address width; bank depth is 2**AW entries (4 by default).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1; held high until the matching ack.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-007 addr0, addr1  input  AW each  bank entry address.
REQ-008 wdata0, wdata1  input  DW each  write data.
REQ-009 gnt0, gnt1  output  1 each  registered; high for the single ACCESS cycle of the granted requester.
REQ-010 ack0, ack1  output  1 each  registered; one-cycle completion pulse to the served requester.
REQ-011 rdata  output  DW  registered read data; valid only in the cycle a read ack is high.
REQ-012 busy  output  1  registered; high in ACCESS and DONE.
REQ-013 cnt0, cnt1  output  8 each  completed-transaction counters (see Configuration).

Function
REQ-014 Block SHALL own an internal bank of 2**AW x DW flip-flops, shared between two requesters.
REQ-015 FSM SHALL have three states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when req0 or req1 is sampled high.
- ACCESS -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-016 On IDLE->ACCESS, the winner's we/addr/wdata SHALL be captured into internal registers; later input changes SHALL NOT affect the transaction.
REQ-017 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; with one request high, it wins.
REQ-018 The last-served pointer SHALL update only on IDLE->ACCESS.
REQ-019 The last-served pointer SHALL reset so that requester 0 wins the first tie.
REQ-020 Write: the bank entry SHALL update at the clock edge ending ACCESS.
REQ-021 Read: the entry SHALL be registered into rdata at the same edge; rdata SHALL be 0 in every cycle without a read ack.
REQ-022 Latency: req sampled at edge N -> gnt high in cycle N+1 -> ack high in cycle N+2. One transaction occupies 3 cycles; peak throughput is one transaction per 3 cycles.
REQ-023 Only the served requester's gnt/ack SHALL assert. gnt0&gnt1 and ack0&ack1 SHALL never be high together.
REQ-024 Handshake: a requester drops req at the edge where it sees ack. A req still high in the IDLE after ack SHALL be treated as a new request.
REQ-025 A request arriving during ACCESS/DONE SHALL wait, unaffected, until the next IDLE.
REQ-026 A loser's request SHALL remain pending and SHALL win the next IDLE if still asserted.
REQ-027 Write followed by read to the same address SHALL return the new data. There is no data forwarding hazard, because transactions are serialized.

Reset
REQ-028 While reset is high at a clock edge: state becomes IDLE; gnt0/1, ack0/1, busy, rdata and cnt0/1 become 0; all bank entries become 0; pointer becomes "last served = 1".
REQ-029 Reset in ACCESS or DONE SHALL abort the transaction: no ack is issued and a pending write is discarded.
REQ-030 Requests sampled in the same edge as reset SHALL be ignored.

Configuration
REQ-031 Macro REG_BANK_ARB_STATS_EN:
- Defined: cnt0/cnt1 SHALL increment by 1 on each ack0/ack1 and wrap 255 -> 0.
- Undefined: cnt0/cnt1 SHALL be tied to 0, no counter flops SHALL be built, and ports SHALL remain present.

Verification
REQ-032 Reset, then req0 write addr=2 wdata=8'hA5 at edge N -> gnt0 in cycle N+1, ack0 in cycle N+2, busy high in N+1..N+2.
REQ-033 Then req1 read addr=2 -> ack1 with rdata=8'hA5 in the same cycle; rdata=0 in all other cycles.
REQ-034 req0 and req1 both held high for 12 cycles from reset -> grant order 0,1,0,1; each ack 3 cycles apart; never two gnts together.
REQ-035 Reset pulsed during ACCESS of a write 8'h3C to addr 1 -> no ack; a later read of addr 1 returns 8'h00.
REQ-036 With REG_BANK_ARB_STATS_EN, 257 req0 transactions -> cnt0=1, cnt1=0; without the macro -> cnt0=cnt1=0 throughout.
REQ-037 Change addr0/wdata0 during ACCESS of write addr=0 8'h11 -> entry 0 reads 8'h11; the other entries are unchanged.

Source files
------------

// File: rtl/reg_bank_arb_if.sv
// Request/grant bus between two requesters and the shared register bank arbiter.
// Carries both requesters' access fields and the arbiter's registered responses.
// The master drives req/we/addr/wdata. The slave (arbiter) drives gnt/ack/rdata/busy/cnt.
interface reg_bank_arb_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [7:0]    cnt0;
  logic [7:0]    cnt1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, ack0, ack1, rdata, busy, cnt0, cnt1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, ack0, ack1, rdata, busy, cnt0, cnt1
  );
endinterface

// File: rtl/reg_bank_arb.sv
// Two-requester round-robin arbiter in front of a 2**AW x DW flop register bank.
// Latency: req sampled at edge N -> gnt in cycle N+1 -> ack/rdata in cycle N+2; one transaction per 3 cycles.
// Backpressure: losers and requests arriving while busy simply stay pending until the next IDLE.
// Optional completion counters are enabled with the REG_BANK_ARB_STATS_EN macro.
module reg_bank_arb #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic           clk,
  input  logic           reset,
  reg_bank_arb_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        r_state;
  logic          r_last;   // last served requester; 1 so requester 0 wins the first tie
  logic          r_sel;    // requester owning the in-flight transaction
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;
  logic [DW-1:0] r_bank [DEPTH];

  // Round-robin pick: on a tie the requester not served last wins.
  logic w_win;
  assign w_win = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

  // Transaction FSM: capture winner in IDLE, perform access at the end of ACCESS, release in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_state <= ACCESS;
            r_sel   <= w_win;
            r_last  <= w_win;
            r_we    <= w_win ? bus.we1    : bus.we0;
            r_addr  <= w_win ? bus.addr1  : bus.addr0;
            r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
          end
        end
        ACCESS: begin
          r_state <= DONE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_ack0  <= ~r_sel;
          r_ack1  <= r_sel;
          if (r_we) begin
            r_bank[r_addr] <= r_wdata;
            r_rdata        <= '0;
          end else begin
            r_rdata <= r_bank[r_addr];
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_rdata <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.ack0  = r_ack0;
  assign bus.ack1  = r_ack1;
  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;

`ifdef REG_BANK_ARB_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  // Count completions as the ack is issued; 8-bit wrap is intentional.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (r_state == ACCESS) begin
      if (r_sel) r_cnt1 <= r_cnt1 + 8'd1;
      else       r_cnt0 <= r_cnt0 + 8'd1;
    end
  end

  assign bus.cnt0 = r_cnt0;
  assign bus.cnt1 = r_cnt1;
`else
  assign bus.cnt0 = 8'd0;
  assign bus.cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed bench for reg_bank_arb: scoreboard of expected acks/read data checked by a monitor,
// plus per-step latency, arbitration-order, reset-abort and counter checks.
module tb_reg_bank_arb;

  logic clk;
  logic reset;

  reg_bank_arb_if #(.DW(8), .AW(2)) bus ();

  reg_bank_arb #(.DW(8), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         who;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every ack must match the scoreboard head; rdata is zero outside read acks.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("gnt_mutex", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
        if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_who", {30'd0, bus.ack1, bus.ack0}, e.who ? 32'd2 : 32'd1);
            check(e.rd ? "read_data" : "rdata_on_write", {24'd0, bus.rdata}, e.rd ? {24'd0, e.data} : 32'd0);
          end
        end else begin
          check("rdata_idle_zero", {24'd0, bus.rdata}, 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input bit who, input bit req, input bit we, input logic [1:0] a, input logic [7:0] d);
    if (!who) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One transaction from IDLE, checking gnt/ack latency and busy; optionally disturbs inputs in ACCESS.
  task automatic txn(input bit who, input bit we, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input bit scramble);
    sb.push_back('{who, !we, exp_rd});
    drive(who, 1'b1, we, a, d);
    @(negedge clk);
    check("gnt_latency", {30'd0, bus.gnt1, bus.gnt0}, who ? 32'd2 : 32'd1);
    check("busy_access", {31'd0, bus.busy}, 32'd1);
    if (scramble) drive(who, 1'b1, we, ~a, ~d);
    @(negedge clk);
    check("ack_latency", {30'd0, bus.ack1, bus.ack0}, who ? 32'd2 : 32'd1);
    check("busy_done", {31'd0, bus.busy}, 32'd1);
    drive(who, 1'b0, we, a, d);
    @(negedge clk);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_cnt0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    do_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_gnt",   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check("rst_ack",   {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    check("rst_cnt0",  {24'd0, bus.cnt0}, 32'd0);
    check("rst_cnt1",  {24'd0, bus.cnt1}, 32'd0);

    // Write then read back across requesters
    txn(1'b0, 1'b1, 2'd2, 8'hA5, 8'h00, 1'b0);
    txn(1'b1, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
    txn(1'b1, 1'b1, 2'd3, 8'h5A, 8'h00, 1'b0);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 8'h5A, 1'b0);
    txn(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
    txn(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

    // Both requesters held continuously from reset: grants alternate 0,1,0,1
    do_reset();
    sb.push_back('{1'b0, 1'b1, 8'h00});
    sb.push_back('{1'b1, 1'b1, 8'h00});
    sb.push_back('{1'b0, 1'b1, 8'h00});
    sb.push_back('{1'b1, 1'b1, 8'h00});
    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("rr_gnt0", {31'd0, bus.gnt0}, (k == 1 || k == 7)  ? 32'd1 : 32'd0);
      check("rr_gnt1", {31'd0, bus.gnt1}, (k == 4 || k == 10) ? 32'd1 : 32'd0);
      check("rr_ack0", {31'd0, bus.ack0}, (k == 2 || k == 8)  ? 32'd1 : 32'd0);
      check("rr_ack1", {31'd0, bus.ack1}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    check("rr_busy_end", {31'd0, bus.busy}, 32'd0);
    check("rr_sb_empty", sb.size(), 32'd0);

    // Inputs changed during ACCESS must not affect the captured write
    do_reset();
    txn(1'b0, 1'b1, 2'd0, 8'h11, 8'h00, 1'b1);
    txn(1'b1, 1'b0, 2'd0, 8'h00, 8'h11, 1'b0);
    txn(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0);
    txn(1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0);
    txn(1'b0, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0);

    // Reset during ACCESS aborts the write and suppresses the ack
    drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h3C);
    @(negedge clk);
    check("abort_gnt", {31'd0, bus.gnt0}, 32'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 2'd1, 8'h3C);
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {29'd0, bus.busy, bus.gnt0, bus.ack0}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    end
    txn(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0);

    // Completion counters over 257 requester-0 transactions
    do_reset();
    for (int i = 0; i < 257; i++) txn(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
`ifdef REG_BANK_ARB_STATS_EN
    exp_cnt0 = 8'd1;
`else
    exp_cnt0 = 8'd0;
`endif
    check("cnt0_after_257", {24'd0, bus.cnt0}, {24'd0, exp_cnt0});
    check("cnt1_after_257", {24'd0, bus.cnt1}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
